skid_reg: RTL and testbench
===========================

# skid_reg

Backward-path pipeline register (skid buffer) for valid/ready streams. It registers `din_ready` so the upstream ready path is cut with no combinational dependency on `dout_ready`, while keeping full throughput. It complements the forward data register, and the two are chained when both timing paths must be broken. It is inserted between any producer/consumer pair carrying `DIN`-bit data.

## Interface
- `DIN`, default 0 (must be overridden, ≥1): data width in bits.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din_valid`  in  1  upstream data valid.
- `din_data`  in  `DIN`  upstream data.
- `din_ready`  out  1  upstream ready. Driven directly from a flop.
- `dout_valid`  out  1  downstream data valid.
- `dout_data`  out  `DIN`  downstream data.
- `dout_ready`  in  1  downstream ready.

## Operation
- A transfer occurs on a port in a cycle where valid and ready are both 1.
- Base mode holds one skid entry: `skid_valid` and `skid_data`.
- Skid empty:
  - `dout_valid = din_valid` and `dout_data = din_data` (combinational pass).
  - `din_valid & !dout_ready & din_ready`: capture `din_data` into skid; `skid_valid` is 1 next cycle.
- Skid full:
  - `dout_valid = 1`, `dout_data = skid_data`.
  - `dout_ready = 1`: skid clears next cycle.
- `din_ready` flop takes the next-cycle value of `!skid_valid`. No input is accepted while the skid is full.
- Ordering is strictly FIFO. No data is dropped or duplicated.
- `din_valid` must not be retracted before its transfer completes. `din_data` must stay stable while valid.
- Reset:
  - `skid_valid = 0`, `din_ready = 0`, `dout_valid` follows the empty-skid rule.
  - Data flops are not reset.
  - `din_ready` rises on the first clock edge after `rst` falls.
  - Any transfer presented while `rst = 1` is discarded.
  - Reset mid-operation drops held data with no output glitch beyond `dout_valid` falling to `din_valid`.

## Timing
- Base mode: zero-cycle latency through the block when the skid is empty.
- Throughput is 1 transfer/cycle under continuous `dout_ready = 1`.
- One stall costs exactly one skid entry. `din_ready` drops the cycle after the stall edge.
- After `dout_ready` returns, `din_ready` is 1 one cycle later. The skid drains in that same cycle.
- Simultaneous cases:
  - Skid full with `dout_ready = 1`: the skid drains, and no input is accepted that cycle because `din_ready = 0`.
  - Skid empty with `din_valid = 1` and `dout_ready = 1`: pass-through; the skid stays empty.

## Configuration
- Macro `SKID_REG_FWD_EN`.
- Undefined: base mode above. Forward path is combinational.
- Defined: full registered slice. `dout_valid` and `dout_data` come from an output register, and `din_ready` stays registered. It uses a two-entry state machine (`out_reg` + `skid`), with `din_ready = (state != FULL)` held registered:
  - EMPTY (0 held):
    - `din` xfer → BUSY (load `out_reg`).
  - BUSY (`out_reg` valid):
    - in xfer & out xfer → BUSY (load `out_reg`).
    - in xfer & !out → FULL (load `skid`).
    - !in & out xfer → EMPTY.
    - otherwise stay.
  - FULL:
    - out xfer → BUSY (`out_reg <= skid`).
    - `din_ready = 0`.
  - Latency is 1 cycle. Throughput stays 1/cycle. Reset state is EMPTY with `dout_valid = 0`.

## Structure
- Shared package `skid_reg_pkg`:
  - state enum typedef `skid_state_t` (EMPTY, BUSY, FULL), 2 bits.
  - localparam `SKID_DEPTH_FWD = 2`.
- No sub-module. Both modes live in one module, selected by `ifdef`. The skid entry logic is shared.

## Test plan
- Reset: hold `rst` 3 cycles → `din_ready = 0`, `dout_valid = 0`, or `dout_valid` equal to `din_valid` in base mode. `din_ready = 1` one cycle after release.
- Streaming: push 0x01..0x10 with `dout_ready = 1` → 16 outputs, in order, on consecutive cycles. Base: same cycle as input. FWD: +1 cycle.
- Single stall: while streaming, drop `dout_ready` for 1 cycle at item 0x05.
  - Skid captures 0x05 (base) or 0x06 (FWD).
  - `din_ready = 0` next cycle.
  - No loss or duplication.
- Long backpressure: `dout_ready = 0` for 10 cycles with `din_valid = 1` → exactly 1 (base) or 2 (FWD) items accepted, `din_ready = 0` held. On release the items drain in order.
- Random valid/ready at 50%/50%, 2000 items, scoreboard → in-order match, zero drops. Check `din_ready` has no same-cycle dependency on `dout_ready`.
- Reset mid-operation with skid FULL holding 0xAA → after reset, 0xAA never appears on `dout`. The next pushed item 0x55 is output first.

Source files
------------

// File: rtl/skid_reg_pkg.sv
// Shared types and constants for the skid_reg backward-path register slice.
package skid_reg_pkg;

    // Occupancy of the registered-forward slice: nothing held, out_reg only, out_reg + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int SKID_DEPTH_FWD = 2;

endpackage

// File: rtl/skid_reg_if.sv
// Valid/ready stream pair seen by skid_reg: upstream (din_*) and downstream (dout_*).
interface skid_reg_if #(
    parameter int DIN = 0
);
    logic           din_valid;
    logic [DIN-1:0] din_data;
    logic           din_ready;
    logic           dout_valid;
    logic [DIN-1:0] dout_data;
    logic           dout_ready;

    // master is the environment around the slice; slave is the slice itself.
    modport master (
        output din_valid, din_data, dout_ready,
        input  din_ready, dout_valid, dout_data
    );

    modport slave (
        input  din_valid, din_data, dout_ready,
        output din_ready, dout_valid, dout_data
    );
endinterface

// File: rtl/skid_reg.sv
// Skid buffer that registers din_ready. Define SKID_REG_FWD_EN to also register
// dout_valid/dout_data (two-entry full slice); otherwise the forward path is combinational.
module skid_reg
    import skid_reg_pkg::*;
#(
    parameter int DIN = 0
) (
    input logic       clk,
    input logic       rst,
    skid_reg_if.slave bus
);

    logic           din_ready_q;
    logic           in_xfer;
    logic           skid_load;
    logic [DIN-1:0] skid_data;

    assign bus.din_ready = din_ready_q;
    assign in_xfer       = bus.din_valid & din_ready_q;

    // NOTE: data flops carry no reset; only the valid/state bits need a known value after rst.
    always_ff @(posedge clk) begin
        if (skid_load) skid_data <= bus.din_data;
    end

`ifdef SKID_REG_FWD_EN
    skid_state_t    state, state_next;
    logic [DIN-1:0] out_data;
    logic           out_xfer;
    logic           out_load_din;
    logic           out_load_skid;

    assign bus.dout_valid = (state != EMPTY);
    assign bus.dout_data  = out_data;
    assign out_xfer       = (state != EMPTY) & bus.dout_ready;

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            din_ready_q <= 1'b0;
        end else begin
            state       <= state_next;
            din_ready_q <= (state_next != FULL);
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_next    = state;
        out_load_din  = 1'b0;
        out_load_skid = 1'b0;
        skid_load     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next   = BUSY;
                    out_load_din = 1'b1;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    out_load_din = 1'b1;
                end else if (in_xfer) begin
                    state_next = FULL;
                    skid_load  = 1'b1;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // din_ready is low here, so only the drain of the skid into out_reg can happen.
                if (out_xfer) begin
                    state_next    = BUSY;
                    out_load_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (out_load_din)       out_data <= bus.din_data;
        else if (out_load_skid) out_data <= skid_data;
    end

`else
    logic skid_valid;
    logic skid_valid_next;

    // The skid only fills when an accepted word cannot leave in the same cycle.
    always_comb begin
        skid_valid_next = skid_valid;
        skid_load       = 1'b0;
        if (skid_valid) begin
            if (bus.dout_ready) skid_valid_next = 1'b0;
        end else if (in_xfer && !bus.dout_ready) begin
            skid_valid_next = 1'b1;
            skid_load       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid  <= 1'b0;
            din_ready_q <= 1'b0;
        end else begin
            skid_valid  <= skid_valid_next;
            din_ready_q <= !skid_valid_next;
        end
    end

    assign bus.dout_valid = skid_valid | bus.din_valid;
    assign bus.dout_data  = skid_valid ? skid_data : bus.din_data;
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Self-checking bench for skid_reg: directed table, streaming/stall/reset sequences and
// a randomized run against an occupancy + FIFO reference model (both build modes).
module tb_skid_reg;
    import skid_reg_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         e_dr;
        logic         e_dv;
        logic [W-1:0] e_dd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    skid_reg_if #(.DIN(W)) bus ();

    skid_reg #(.DIN(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_out   = 0;
    bit           model_on = 1'b0;
    logic         last_dr;
    logic         last_dv;
    logic [W-1:0] last_dd;
    logic [W-1:0] last_out;
    logic [W-1:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, probe din_ready against both dout_ready values,
    // sample at the falling edge, update the reference model, then advance past the rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        logic dr_a;
        int   held;
        bus.din_valid  = v;
        bus.din_data   = d;
        bus.dout_ready = !r;
        #1 dr_a = bus.din_ready;
        bus.dout_ready = r;
        @(negedge clk);
        last_dr = bus.din_ready;
        last_dv = bus.dout_valid;
        last_dd = bus.dout_data;
        check("din_ready_indep_of_dout_ready", 32'(last_dr), 32'(dr_a));
        held = sb_q.size();
        if (model_on) begin
`ifdef SKID_REG_FWD_EN
            check("model_din_ready", 32'(last_dr), 32'(held < SKID_DEPTH_FWD));
            check("model_dout_valid", 32'(last_dv), 32'(held > 0));
`else
            check("model_din_ready", 32'(last_dr), 32'(held == 0));
            check("model_dout_valid", 32'(last_dv), 32'((held > 0) || (v == 1'b1)));
`endif
        end
        if (!rst) begin
            if (v && last_dr) sb_q.push_back(d);
            if (last_dv && r) begin
                n_out++;
                last_out = last_dd;
                check("output_has_pending_item", 32'(sb_q.size() > 0), 32'(1));
                if (sb_q.size() > 0) check("sb_order", 32'(last_dd), 32'(sb_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t vec(input logic v, input logic [W-1:0] d, input logic r,
                                 input logic e_dr, input logic e_dv, input logic [W-1:0] e_dd);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.e_dr = e_dr; x.e_dv = e_dv; x.e_dd = e_dd;
        return x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[11];
        int           acc;
        int           n0;
        int           sent;
        int           n_aa;
        bit           pv;
        bit           got;
        logic         r;
        logic [W-1:0] pd;
        logic [W-1:0] first;

`ifdef SKID_REG_FWD_EN
        tbl[0]  = vec(1, 8'h01, 1, 1, 0, 8'h00);
        tbl[1]  = vec(1, 8'h02, 1, 1, 1, 8'h01);
        tbl[2]  = vec(1, 8'h03, 1, 1, 1, 8'h02);
        tbl[3]  = vec(1, 8'h04, 1, 1, 1, 8'h03);
        tbl[4]  = vec(1, 8'h05, 1, 1, 1, 8'h04);
        tbl[5]  = vec(1, 8'h06, 0, 1, 1, 8'h05);
        tbl[6]  = vec(1, 8'h07, 1, 0, 1, 8'h05);
        tbl[7]  = vec(1, 8'h07, 1, 1, 1, 8'h06);
        tbl[8]  = vec(1, 8'h08, 1, 1, 1, 8'h07);
        tbl[9]  = vec(0, 8'h00, 1, 1, 1, 8'h08);
        tbl[10] = vec(0, 8'h00, 1, 1, 0, 8'h00);
`else
        tbl[0]  = vec(1, 8'h01, 1, 1, 1, 8'h01);
        tbl[1]  = vec(1, 8'h02, 1, 1, 1, 8'h02);
        tbl[2]  = vec(1, 8'h03, 1, 1, 1, 8'h03);
        tbl[3]  = vec(1, 8'h04, 1, 1, 1, 8'h04);
        tbl[4]  = vec(1, 8'h05, 0, 1, 1, 8'h05);
        tbl[5]  = vec(1, 8'h06, 1, 0, 1, 8'h05);
        tbl[6]  = vec(1, 8'h06, 1, 1, 1, 8'h06);
        tbl[7]  = vec(1, 8'h07, 1, 1, 1, 8'h07);
        tbl[8]  = vec(1, 8'h08, 1, 1, 1, 8'h08);
        tbl[9]  = vec(0, 8'h00, 1, 1, 0, 8'h00);
        tbl[10] = vec(0, 8'h00, 1, 1, 0, 8'h00);
`endif

        bus.din_valid  = 1'b0;
        bus.din_data   = '0;
        bus.dout_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for 3 cycles with traffic presented, then released.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h33, 1'b1);
            check("rst_din_ready", 32'(last_dr), 32'(0));
`ifdef SKID_REG_FWD_EN
            check("rst_dout_valid", 32'(last_dv), 32'(0));
`else
            check("rst_dout_valid", 32'(last_dv), 32'(1));
`endif
        end
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);
        check("release_din_ready_before_edge", 32'(last_dr), 32'(0));
        cycle(1'b0, 8'h00, 1'b1);
        check("release_din_ready_after_edge", 32'(last_dr), 32'(1));
        model_on = 1'b1;

        // Directed single-stall table.
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r);
            check($sformatf("tbl%0d_din_ready", i), 32'(last_dr), 32'(tbl[i].e_dr));
            check($sformatf("tbl%0d_dout_valid", i), 32'(last_dv), 32'(tbl[i].e_dv));
            if (tbl[i].e_dv) check($sformatf("tbl%0d_dout_data", i), 32'(last_dd), 32'(tbl[i].e_dd));
        end

        // Streaming 0x01..0x10 with dout_ready held high.
        for (int i = 0; i <= 16; i++) begin
            cycle(1'(i < 16), W'(i + 1), 1'b1);
            check("stream_din_ready", 32'(last_dr), 32'(1));
`ifdef SKID_REG_FWD_EN
            check("stream_dout_valid", 32'(last_dv), 32'(i >= 1));
            if (i >= 1) check("stream_dout_data", 32'(last_dd), 32'(i));
`else
            check("stream_dout_valid", 32'(last_dv), 32'(i < 16));
            if (i < 16) check("stream_dout_data", 32'(last_dd), 32'(i + 1));
`endif
        end

        // Long backpressure: 10 stalled cycles with din_valid held high.
        pd  = 8'h20;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, pd, 1'b0);
            if (last_dr) begin
                acc++;
                pd++;
            end
        end
`ifdef SKID_REG_FWD_EN
        check("bp_accepted", 32'(acc), 32'(SKID_DEPTH_FWD));
`else
        check("bp_accepted", 32'(acc), 32'(1));
`endif
        check("bp_din_ready_held_low", 32'(last_dr), 32'(0));
        n0 = n_out;
        pv = 1'b1;
        for (int i = 0; i < 12 && (pv || sb_q.size() > 0); i++) begin
            cycle(pv, pd, 1'b1);
            if (pv && last_dr) pv = 1'b0;
        end
        check("bp_drain_count", 32'(n_out - n0), 32'(acc + 1));
        check("bp_sb_empty", 32'(sb_q.size()), 32'(0));

        // Randomized valid/ready, 2000 items.
        n0   = n_out;
        sent = 0;
        pv   = 1'b0;
        pd   = '0;
        for (int c = 0; c < 20000 && (n_out - n0) < 2000; c++) begin
            if (!pv && sent < 2000 && $urandom_range(0, 1) == 1) begin
                pv = 1'b1;
                pd = W'($urandom);
            end
            r = 1'($urandom_range(0, 1));
            cycle(pv, pd, r);
            if (pv && last_dr) begin
                pv = 1'b0;
                sent++;
            end
        end
        check("rand_items_out", 32'(n_out - n0), 32'(2000));
        check("rand_sb_empty", 32'(sb_q.size()), 32'(0));

        // Reset mid-operation while the skid holds 0xAA.
`ifdef SKID_REG_FWD_EN
        cycle(1'b1, 8'hA9, 1'b0);
`endif
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("full_before_reset_din_ready", 32'(last_dr), 32'(0));
        rst      = 1'b1;
        model_on = 1'b0;
        sb_q.delete();
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("midrst_dout_valid", 32'(last_dv), 32'(0));
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);
        check("midrst_release_din_ready", 32'(last_dr), 32'(0));
        model_on = 1'b1;
        n0   = n_out;
        pv   = 1'b1;
        got  = 1'b0;
        n_aa = 0;
        first = '0;
        for (int i = 0; i < 6; i++) begin
            cycle(pv, 8'h55, 1'b1);
            if (pv && last_dr) pv = 1'b0;
            if (n_out > n0) begin
                if (!got) first = last_out;
                if (last_dv && last_dd == 8'hAA) n_aa++;
                got = 1'b1;
            end
        end
        check("midrst_got_output", 32'(got), 32'(1));
        check("midrst_first_output", 32'(first), 32'(8'h55));
        check("midrst_no_aa", 32'(n_aa), 32'(0));
        check("midrst_single_output", 32'(n_out - n0), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
